// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared widths, counts and types for the 32x32 register file
package regfile_pkg;
  localparam int REG_DATA_W = 32;
  localparam int REG_ADDR_W = 5;
  localparam int REG_COUNT  = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_DATA_W-1:0] reg_data_t;
endpackage

// File: rtl/register_file32_if.sv
// rtl/register_file32_if.sv - read/write port bundle between datapath (master) and register file (slave)
interface register_file32_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W
);
  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (
    output rd_addr1, rd_addr2, wr_en, wr_addr, wr_data,
    input  rd_data1, rd_data2
  );

  modport slave (
    input  rd_addr1, rd_addr2, wr_en, wr_addr, wr_data,
    output rd_data1, rd_data2
  );
endinterface

// File: rtl/reg32.sv
// rtl/reg32.sv - one register-file entry: DATA_W flop with synchronous active-high reset and load enable
module reg32
  import regfile_pkg::*;
#(
  parameter int DATA_W = REG_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);
  // Reset wins over a coincident load so a write in the reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end
endmodule

// File: rtl/register_file32.sv
// rtl/register_file32.sv - 2R1W register file, r0 hardwired to zero; REGFILE_BYPASS_EN enables write-through reads
module register_file32
  import regfile_pkg::*;
#(
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input logic               clk,
  input logic               reset,
  register_file32_if.slave  rf
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic              hit1;
  logic              hit2;

  assign regs[0] = '0;

  // Entry 0 is never built, so the decoder only covers addresses 1..DEPTH-1.
  for (genvar i = 1; i < DEPTH; i++) begin : g_reg
    logic load;
    assign load = rf.wr_en && (rf.wr_addr == ADDR_W'(i));
    reg32 #(.DATA_W(DATA_W)) u_reg (
      .clk   (clk),
      .reset (reset),
      .load  (load),
      .d     (rf.wr_data),
      .q     (regs[i])
    );
  end

`ifdef REGFILE_BYPASS_EN
  assign hit1 = rf.wr_en && !reset && (rf.wr_addr != ADDR_W'(REG_ZERO)) && (rf.rd_addr1 == rf.wr_addr);
  assign hit2 = rf.wr_en && !reset && (rf.wr_addr != ADDR_W'(REG_ZERO)) && (rf.rd_addr2 == rf.wr_addr);
`else
  assign hit1 = 1'b0;
  assign hit2 = 1'b0;
`endif

  assign rf.rd_data1 = hit1 ? rf.wr_data : regs[rf.rd_addr1];
  assign rf.rd_data2 = hit2 ? rf.wr_data : regs[rf.rd_addr2];
endmodule

// File: tb/tb_register_file32.sv
// tb/tb_register_file32.sv - directed self-checking bench for register_file32
module tb_register_file32;
  import regfile_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  register_file32_if #(.DATA_W(REG_DATA_W), .ADDR_W(REG_ADDR_W)) rf_if ();

  register_file32 #(.DATA_W(REG_DATA_W), .ADDR_W(REG_ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .rf    (rf_if.slave)
  );

  task automatic chk(input string name, input reg_data_t got, input reg_data_t exp);
    checks++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", name, got, exp);
    else passed++;
  endtask

  task automatic write_reg(input reg_addr_t a, input reg_data_t d);
    @(negedge clk);
    rf_if.wr_en = 1'b1; rf_if.wr_addr = a; rf_if.wr_data = d;
    @(negedge clk);
    rf_if.wr_en = 1'b0;
  endtask

  task automatic test_reset;
    rf_if.rd_addr1 = REG_ZERO; rf_if.rd_addr2 = REG_ZERO;
    #1;
    checks++;
    if (rf_if.rd_data1 !== 32'h0) $display("FAIL pre_reset_r0 got=%h exp=0", rf_if.rd_data1);
    else passed++;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    for (int i = 0; i < REG_COUNT; i++) begin
      rf_if.rd_addr1 = reg_addr_t'(i);
      rf_if.rd_addr2 = reg_addr_t'(REG_COUNT - 1 - i);
      #1;
      checks++;
      if (rf_if.rd_data1 !== 32'h0 || rf_if.rd_data2 !== 32'h0)
        $display("FAIL reset_sweep addr=%0d got=%h/%h exp=0", i, rf_if.rd_data1, rf_if.rd_data2);
      else passed++;
    end
  endtask

  task automatic test_basic_write;
    write_reg(5'd5, 32'hDEADBEEF);
    rf_if.rd_addr1 = 5'd5; rf_if.rd_addr2 = 5'd5;
    #1;
    checks++;
    if (rf_if.rd_data1 !== 32'hDEADBEEF) $display("FAIL basic_rd1 got=%h exp=deadbeef", rf_if.rd_data1);
    else passed++;
    checks++;
    if (rf_if.rd_data2 !== 32'hDEADBEEF) $display("FAIL basic_rd2 got=%h exp=deadbeef", rf_if.rd_data2);
    else passed++;
  endtask

  task automatic test_zero_reg;
    @(negedge clk);
    rf_if.rd_addr1 = REG_ZERO;
    rf_if.wr_en = 1'b1; rf_if.wr_addr = REG_ZERO; rf_if.wr_data = 32'hFFFFFFFF;
    #1;
    checks++;
    if (rf_if.rd_data1 !== 32'h0) $display("FAIL zero_same_cycle got=%h exp=0", rf_if.rd_data1);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); rf_if.wr_en = 1'b0;
      #1;
      checks++;
      if (rf_if.rd_data1 !== 32'h0) $display("FAIL zero_later cyc=%0d got=%h exp=0", i, rf_if.rd_data1);
      else passed++;
    end
  endtask

  task automatic test_read_during_write;
    reg_data_t exp_same;
`ifdef REGFILE_BYPASS_EN
    exp_same = 32'h22222222;
`else
    exp_same = 32'h11111111;
`endif
    write_reg(5'd7, 32'h11111111);
    rf_if.rd_addr1 = 5'd7; rf_if.rd_addr2 = 5'd6;
    rf_if.wr_en = 1'b1; rf_if.wr_addr = 5'd7; rf_if.wr_data = 32'h22222222;
    #1;
    chk("rdw_same_cycle", rf_if.rd_data1, exp_same);
    chk("rdw_other_port", rf_if.rd_data2, 32'h0);
    @(negedge clk); rf_if.wr_en = 1'b0;
    #1;
    chk("rdw_next_cycle", rf_if.rd_data1, 32'h22222222);
  endtask

  task automatic test_reset_beats_write;
    write_reg(5'd3, 32'hA5A5A5A5);
    rf_if.rd_addr1 = 5'd3; rf_if.rd_addr2 = 5'd5;
    #1;
    chk("rbw_before", rf_if.rd_data1, 32'hA5A5A5A5);
    @(negedge clk);
    reset = 1'b1;
    rf_if.wr_en = 1'b1; rf_if.wr_addr = 5'd3; rf_if.wr_data = 32'h12345678;
    #1;
    chk("rbw_no_bypass", rf_if.rd_data1, 32'hA5A5A5A5);
    @(negedge clk);
    reset = 1'b0; rf_if.wr_en = 1'b0;
    #1;
    chk("rbw_r3_after", rf_if.rd_data1, 32'h0);
    chk("rbw_r5_after", rf_if.rd_data2, 32'h0);
  endtask

  task automatic test_alu_loop;
    reg_data_t alu_out;
    write_reg(5'd1, 32'd5);
    write_reg(5'd2, 32'd7);
    rf_if.rd_addr1 = 5'd1; rf_if.rd_addr2 = 5'd2;
    #1;
    chk("alu_a", rf_if.rd_data1, 32'd5);
    chk("alu_b", rf_if.rd_data2, 32'd7);
    alu_out = rf_if.rd_data1 + rf_if.rd_data2;
    write_reg(5'd3, alu_out);
    rf_if.rd_addr1 = 5'd3;
    #1;
    chk("alu_r3", rf_if.rd_data1, 32'd12);
  endtask

  task automatic test_back_to_back;
    for (int i = 1; i < REG_COUNT; i++) begin
      @(negedge clk);
      rf_if.wr_en = 1'b1; rf_if.wr_addr = reg_addr_t'(i);
      rf_if.wr_data = (32'h01010101 * i) ^ 32'hC0DE0000;
    end
    @(negedge clk);
    rf_if.wr_en = 1'b0; rf_if.wr_addr = 5'd9; rf_if.wr_data = 32'hBAD0BAD0;
    @(negedge clk);
    for (int i = 0; i < REG_COUNT; i++) begin
      rf_if.rd_addr1 = reg_addr_t'(i);
      rf_if.rd_addr2 = reg_addr_t'(REG_COUNT - 1 - i);
      #1;
      chk("b2b_rd1", rf_if.rd_data1, (i == 0) ? 32'h0 : ((32'h01010101 * i) ^ 32'hC0DE0000));
      chk("b2b_rd2", rf_if.rd_data2,
          (i == REG_COUNT - 1) ? 32'h0 : ((32'h01010101 * (REG_COUNT - 1 - i)) ^ 32'hC0DE0000));
    end
  endtask

  initial begin
    rf_if.rd_addr1 = '0; rf_if.rd_addr2 = '0;
    rf_if.wr_en = 1'b0; rf_if.wr_addr = '0; rf_if.wr_data = '0;
    test_reset();
    test_basic_write();
    test_zero_reg();
    test_read_during_write();
    test_reset_beats_write();
    test_alu_loop();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
